clock_monitor: RTL and testbench

Companion to the system clock divider: samples a divided clock (`clock_in`) in the fast `clk` domain and synchronizes it. It emits single-cycle rise/fall enable pulses, measures every half-period in `clk` cycles, and checks each measurement against an expected value. It reports lock, a sticky frequency error and a stall condition, so the CPU clocking path can be checked in hardware and in simulation.

---
 rtl/clock_monitor.sv | 176 +++++++++++++++++
 tb/tb_clock_monitor.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/clock_monitor.sv
// -----------------------------------------------------------------------------
// clock_monitor
//
// Samples a divided clock (clock_in) in the clk domain through a three-flop
// synchronizer. It emits one-cycle rise/fall pulses, measures every
// half-period in clk cycles and checks each measurement against
// EXPECTED +/- TOL. It reports lock, a sticky frequency error and a stall.
//
// Ports
//   clk          in   system clock, all logic on its rising edge
//   reset        in   synchronous, active-low reset
//   clock_in     in   divided clock under test (asynchronous)
//   rise_pulse   out  one-cycle pulse per detected rising edge
//   fall_pulse   out  one-cycle pulse per detected falling edge
//   half_period  out  last measured edge-to-edge interval (CW bits)
//   period_valid out  one-cycle pulse when half_period updates
//   locked       out  LOCK_COUNT consecutive passing measurements seen
//   error        out  sticky: failing measurement or timeout while locked
//   stall        out  no edge seen for 2*EXPECTED or more cycles
//   dbg_state    out  current FSM state (0 idle, 1 track, 2 locked)
//
// Handshake: there is no backpressure. Every output pulse is a one-cycle
// qualifier; half_period is only meaningful in the cycle period_valid is high
// and holds its value otherwise.
// -----------------------------------------------------------------------------
module clock_monitor #(
   parameter int EXPECTED   = 6,
   parameter int TOL        = 1,
   parameter int LOCK_COUNT = 4,
   parameter int CW         = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clock_in,
   output logic          rise_pulse,
   output logic          fall_pulse,
   output logic [CW-1:0] half_period,
   output logic          period_valid,
   output logic          locked,
   output logic          error,
   output logic          stall,
   output logic [1:0]    dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_TRACK  = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   localparam int GW = $clog2(LOCK_COUNT + 1);
   localparam logic [CW-1:0] C_LO        = CW'(EXPECTED - TOL);
   localparam logic [CW-1:0] C_HI        = CW'(EXPECTED + TOL);
   localparam logic [CW-1:0] C_STALL     = CW'(2 * EXPECTED);
   localparam logic [GW-1:0] C_LOCK_LAST = GW'(LOCK_COUNT - 1);

   logic          r_s1, r_s2, r_s3;
   logic [CW-1:0] r_cnt;
   state_t        r_state;
   logic [GW-1:0] r_good;
   logic          r_rise, r_fall;
   logic [CW-1:0] r_hp;
   logic          r_pv, r_locked, r_error, r_stall;

   logic          w_edge;
   logic [CW-1:0] w_cnt_inc;
   logic [CW-1:0] w_cnt_next;
   logic          w_pass;
   state_t        w_state_next;
   logic [GW-1:0] w_good_next;
   logic          w_locked_next, w_error_next, w_pv_next;
   logic [CW-1:0] w_hp_next;

   assign w_edge     = r_s2 ^ r_s3;
   // Saturating increment; doubles as the measurement m = cnt + 1 on an edge.
   assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
   assign w_cnt_next = w_edge ? '0 : w_cnt_inc;
   assign w_pass     = (w_cnt_inc >= C_LO) && (w_cnt_inc <= C_HI);

   always_comb begin
      w_state_next  = r_state;
      w_good_next   = r_good;
      w_locked_next = r_locked;
      w_error_next  = r_error;
      w_pv_next     = 1'b0;
      w_hp_next     = r_hp;
      case (r_state)
         ST_IDLE: begin
            // First interval after reset is partial, so it is not reported.
            if (w_edge) begin
               w_state_next = ST_TRACK;
               w_good_next  = '0;
            end
         end
         ST_TRACK: begin
            if (w_edge) begin
               w_pv_next = 1'b1;
               w_hp_next = w_cnt_inc;
               if (w_pass) begin
                  w_good_next = r_good + 1'b1;
                  if (r_good == C_LOCK_LAST) begin
                     w_state_next  = ST_LOCKED;
                     w_locked_next = 1'b1;
                  end
               end else begin
                  w_good_next = '0;
               end
            end
         end
         ST_LOCKED: begin
            if (w_edge) begin
               w_pv_next = 1'b1;
               w_hp_next = w_cnt_inc;
               if (!w_pass) begin
                  w_error_next  = 1'b1;
                  w_locked_next = 1'b0;
                  w_good_next   = '0;
                  w_state_next  = ST_TRACK;
               end
            end else if (r_cnt == C_HI) begin
               // No edge by the upper tolerance: clock has stopped or slowed.
               w_error_next  = 1'b1;
               w_locked_next = 1'b0;
               w_good_next   = '0;
               w_state_next  = ST_TRACK;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_s1     <= 1'b0;
         r_s2     <= 1'b0;
         r_s3     <= 1'b0;
         r_cnt    <= '0;
         r_state  <= ST_IDLE;
         r_good   <= '0;
         r_rise   <= 1'b0;
         r_fall   <= 1'b0;
         r_hp     <= '0;
         r_pv     <= 1'b0;
         r_locked <= 1'b0;
         r_error  <= 1'b0;
         r_stall  <= 1'b0;
      end else begin
         r_s1     <= clock_in;
         r_s2     <= r_s1;
         r_s3     <= r_s2;
         r_cnt    <= w_cnt_next;
         r_state  <= w_state_next;
         r_good   <= w_good_next;
         r_rise   <= w_edge & r_s2;
         r_fall   <= w_edge & ~r_s2;
         r_hp     <= w_hp_next;
         r_pv     <= w_pv_next;
         r_locked <= w_locked_next;
         r_error  <= w_error_next;
         // Tracks the counter register, so it drops together with the clear.
         r_stall  <= (w_cnt_next >= C_STALL);
      end
   end

   assign rise_pulse   = r_rise;
   assign fall_pulse   = r_fall;
   assign half_period  = r_hp;
   assign period_valid = r_pv;
   assign locked       = r_locked;
   assign error        = r_error;
   assign stall        = r_stall;
   assign dbg_state    = r_state;

endmodule

// File: tb/tb_clock_monitor.sv
// -----------------------------------------------------------------------------
// tb_clock_monitor
//
// Drives a shared clock_in into two monitors (CW=32 and CW=4). The reference
// model works from toggle times only: each toggle made after clk edge t0
// appears as a pulse at edge t0+3, its measurement is the distance to the
// previous detected edge (saturated to the counter width), and lock / error /
// stall follow from the tolerance rules.
// -----------------------------------------------------------------------------
module tb_clock_monitor;

   localparam int EXPECTED = 6;
   localparam int TOL      = 1;
   localparam int LOCKN    = 4;
   localparam int LO       = EXPECTED - TOL;
   localparam int HI       = EXPECTED + TOL;

   logic        clk;
   logic        reset;
   logic        clock_in;

   logic        rp0, fp0, pv0, lk0, er0, st0;
   logic [31:0] hp0;
   logic [1:0]  ds0;
   logic        rp1, fp1, pv1, lk1, er1, st1;
   logic [3:0]  hp1;
   logic [1:0]  ds1;

   clock_monitor #(.EXPECTED(EXPECTED), .TOL(TOL), .LOCK_COUNT(LOCKN), .CW(32)) u_dut (
      .clk(clk), .reset(reset), .clock_in(clock_in),
      .rise_pulse(rp0), .fall_pulse(fp0), .half_period(hp0), .period_valid(pv0),
      .locked(lk0), .error(er0), .stall(st0), .dbg_state(ds0)
   );

   clock_monitor #(.EXPECTED(EXPECTED), .TOL(TOL), .LOCK_COUNT(LOCKN), .CW(4)) u_sat (
      .clk(clk), .reset(reset), .clock_in(clock_in),
      .rise_pulse(rp1), .fall_pulse(fp1), .half_period(hp1), .period_valid(pv1),
      .locked(lk1), .error(er1), .stall(st1), .dbg_state(ds1)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- model state ----------------
   typedef struct {
      int due;
      bit lvl;
   } ev_t;

   ev_t    ev_q[$];
   int     t;
   int     checks;
   int     errors;
   int     m_last [2];
   bit     m_idle [2];
   int     m_good [2];
   bit     m_lk   [2];
   bit     m_er   [2];
   longint m_hp   [2];
   longint m_max  [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s t=%0d observed=%0d expected=%0d", tag, t, obs, exp);
      end
   endtask

   task automatic model_dut(input int id, input logic rp, input logic fp, input logic pv,
                            input logic lk, input logic er, input logic st,
                            input logic [31:0] hp);
      logic   e_rp, e_fp, e_pv, e_st;
      longint d, m;
      string  p;
      e_rp = 1'b0;
      e_fp = 1'b0;
      e_pv = 1'b0;
      p = (id == 0) ? "w32" : "w4";
      if (reset && ev_q.size() > 0 && ev_q[0].due == t) begin
         d = t - m_last[id];
         m = (d > m_max[id]) ? m_max[id] : d;
         e_rp = ev_q[0].lvl;
         e_fp = !ev_q[0].lvl;
         m_last[id] = t;
         if (m_idle[id]) begin
            m_idle[id] = 1'b0;
            m_good[id] = 0;
         end else begin
            e_pv = 1'b1;
            m_hp[id] = m;
            if (m >= LO && m <= HI) begin
               if (!m_lk[id]) begin
                  m_good[id]++;
                  if (m_good[id] == LOCKN) m_lk[id] = 1'b1;
               end
            end else begin
               if (m_lk[id]) begin
                  m_er[id] = 1'b1;
                  m_lk[id] = 1'b0;
               end
               m_good[id] = 0;
            end
         end
      end else if (reset && m_lk[id] && (t - m_last[id]) == HI + 1) begin
         m_er[id]   = 1'b1;
         m_lk[id]   = 1'b0;
         m_good[id] = 0;
      end
      d = t - m_last[id];
      m = (d > m_max[id]) ? m_max[id] : d;
      e_st = (m >= 2 * EXPECTED);
      chk({p, "_rise"},   {31'd0, rp}, {31'd0, e_rp});
      chk({p, "_fall"},   {31'd0, fp}, {31'd0, e_fp});
      chk({p, "_pvalid"}, {31'd0, pv}, {31'd0, e_pv});
      chk({p, "_halfp"},  hp,          32'(m_hp[id]));
      chk({p, "_locked"}, {31'd0, lk}, {31'd0, m_lk[id]});
      chk({p, "_error"},  {31'd0, er}, {31'd0, m_er[id]});
      chk({p, "_stall"},  {31'd0, st}, {31'd0, e_st});
   endtask

   task automatic step();
      if (!reset) begin
         ev_q.delete();
         for (int id = 0; id < 2; id++) begin
            m_idle[id] = 1'b1;
            m_good[id] = 0;
            m_lk[id]   = 1'b0;
            m_er[id]   = 1'b0;
            m_hp[id]   = 0;
            m_last[id] = t;
         end
         // A high level held through reset reaches the synchronizer as a rise.
         if (clock_in) ev_q.push_back('{due: t + 3, lvl: 1'b1});
         chk("w32_state_idle", {30'd0, ds0}, 32'd0);
         chk("w4_state_idle",  {30'd0, ds1}, 32'd0);
      end
      model_dut(0, rp0, fp0, pv0, lk0, er0, st0, hp0);
      model_dut(1, rp1, fp1, pv1, lk1, er1, st1, {28'd0, hp1});
      if (reset && ev_q.size() > 0 && ev_q[0].due == t) void'(ev_q.pop_front());
   endtask

   // ---------------- driver tasks ----------------
   task automatic cycle();
      @(posedge clk);
      t++;
      #1;
      step();
   endtask

   task automatic half(input int n);
      clock_in = ~clock_in;
      ev_q.push_back('{due: t + 3, lvl: clock_in});
      repeat (n) cycle();
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      cycle();
      reset = 1'b1;
      repeat (3) cycle();
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      checks   = 0;
      errors   = 0;
      t        = 0;
      m_max[0] = 64'hFFFF_FFFF;
      m_max[1] = 64'd15;
      for (int id = 0; id < 2; id++) begin
         m_last[id] = 0;
         m_idle[id] = 1'b1;
         m_good[id] = 0;
         m_lk[id]   = 1'b0;
         m_er[id]   = 1'b0;
         m_hp[id]   = 0;
      end
      reset    = 1'b0;
      clock_in = 1'b0;
      repeat (3) cycle();
      reset = 1'b1;
      repeat (3) cycle();

      // Ideal clock: lock on the fourth measurement.
      repeat (10) half(6);

      // Tolerance boundary, then one interval of 8.
      half(5); half(7); half(5); half(7);
      half(8);

      // Recovery: relock while error stays sticky.
      repeat (6) half(6);

      // Stopped clock while locked: timeout, stall, then restart.
      half(25);
      repeat (6) half(6);

      // One-cycle reset while locked.
      pulse_reset();
      repeat (6) half(6);

      // Long hold: the 4-bit counter saturates at 15.
      half(40);
      repeat (3) half(6);

      // Randomized half-periods around the nominal value.
      repeat (60) half($urandom_range(3, 9));

      // Random intervals with a reset in the middle.
      clock_in = ~clock_in;
      ev_q.push_back('{due: t + 3, lvl: clock_in});
      repeat (4) cycle();
      pulse_reset();
      repeat (30) half($urandom_range(4, 8));
      repeat (5) cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
